pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/load_use_detect.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-address width and default timing parameters.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int DEF_MULDIV_LAT  = 4;
  localparam int DEF_MEM_TIMEOUT = 255;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    MULDIV_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the
// source operands of the instruction in ID. Writes to x0 never hazard.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  uses_rs2,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  mem_read,
  output logic                  hazard
);

  assign hazard = mem_read && (rd_addr != '0) &&
                  ((rd_addr == rs1_addr) || (uses_rs2 && (rd_addr == rs2_addr)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect controller for a 5-stage pipeline: memory wait,
// multi-cycle mul/div, taken branches and load-use hazards.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT  = DEF_MULDIV_LAT,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_is_muldiv,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  id_ex_stall,
  output logic                  ex_mem_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  pc_redirect,
  output logic                  muldiv_start,
  output logic [1:0]            state,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int MD_W = 4;
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

  state_t          state_r, state_nxt;
  logic [MD_W-1:0] md_cnt;
  logic            md_load;
  logic [TO_W-1:0] mem_cnt, mem_cnt_nxt;
  logic            load_use;

  load_use_detect u_load_use (
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .uses_rs2 (id_uses_rs2),
    .rd_addr  (ex_rd_addr),
    .mem_read (ex_mem_read),
    .hazard   (load_use)
  );

  assign state = state_r;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_redirect  = 1'b0;
    muldiv_start = 1'b0;
    md_load      = 1'b0;
    state_nxt    = state_r;

    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      state_nxt    = RUN;
    end else begin
      unique case (state_r)
        RUN: begin
          if (mem_req && !mem_ready) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            state_nxt    = MEM_WAIT;
          end else if (ex_is_muldiv) begin
            muldiv_start = 1'b1;
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
            md_load      = 1'b1;
            state_nxt    = MULDIV_WAIT;
          end else if (ex_branch_taken) begin
            pc_redirect  = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
          end else begin
            state_nxt    = RUN;
          end
        end
        MULDIV_WAIT: begin
          if (md_cnt != '0) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_flush = 1'b1;
          end else begin
            state_nxt    = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // mem_cnt counts completed memory-wait cycles, the RUN cycle that
  // detected the miss included; it saturates at MEM_TIMEOUT.
  always_comb begin
    mem_cnt_nxt = mem_cnt;
    if (state_r == RUN && state_nxt == MEM_WAIT)
      mem_cnt_nxt = TO_W'(1);
    else if (state_r == MEM_WAIT && !mem_ready && mem_cnt != TO_W'(MEM_TIMEOUT))
      mem_cnt_nxt = mem_cnt + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      md_cnt       <= '0;
      mem_cnt      <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state_r <= state_nxt;
      mem_cnt <= mem_cnt_nxt;

      if (md_load)
        md_cnt <= MD_W'(MULDIV_LAT - 2);
      else if (state_r == MULDIV_WAIT && md_cnt != '0)
        md_cnt <= md_cnt - 1'b1;

      if (mem_cnt_nxt == TO_W'(MEM_TIMEOUT))
        mem_timeout <= 1'b1;

      if (pc_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl: a table of RUN-state
// vectors plus hand-written multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
  import pipeline_ctrl_pkg::*;

  localparam int LAT = 4;
  localparam int TO  = 5;
  localparam int CW  = 4;

  // {pc_st, if_id_st, id_ex_st, ex_mem_st, if_id_fl, id_ex_fl, ex_mem_fl, redirect, start}
  localparam logic [8:0] O_NONE = 9'b000000000;
  localparam logic [8:0] O_LU   = 9'b110001000;
  localparam logic [8:0] O_BR   = 9'b000011010;
  localparam logic [8:0] O_MD   = 9'b111000101;
  localparam logic [8:0] O_MDW  = 9'b111000100;
  localparam logic [8:0] O_MEM  = 9'b111100000;
  localparam logic [8:0] O_RST  = 9'b000011100;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic          id_uses_rs2, ex_mem_read, ex_branch_taken, ex_is_muldiv;
  logic          mem_req, mem_ready;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic          if_id_flush, id_ex_flush, ex_mem_flush;
  logic          pc_redirect, muldiv_start, mem_timeout;
  logic [1:0]    state;
  logic [CW-1:0] stall_cycles;
  logic [8:0]    obs;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(
    .MULDIV_LAT  (LAT),
    .MEM_TIMEOUT (TO),
    .CNT_W       (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_uses_rs2     (id_uses_rs2),
    .ex_rd_addr      (ex_rd_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_is_muldiv    (ex_is_muldiv),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_stall        (pc_stall),
    .if_id_stall     (if_id_stall),
    .id_ex_stall     (id_ex_stall),
    .ex_mem_stall    (ex_mem_stall),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .pc_redirect     (pc_redirect),
    .muldiv_start    (muldiv_start),
    .state           (state),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  assign obs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                if_id_flush, id_ex_flush, ex_mem_flush, pc_redirect, muldiv_start};

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic [4:0] rd;
    logic       mem_read;
    logic       branch;
    logic       muldiv;
    logic       mreq;
    logic       mrdy;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs2 = 1'b0; ex_rd_addr = '0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_is_muldiv = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Applies one reset edge; returns at the following negedge with rst low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_in();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();

    vecs[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "idle"};
    vecs[1]  = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   "lu_rs1"};
    vecs[2]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "lu_x0"};
    vecs[3]  = '{5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_LU,   "lu_rs2"};
    vecs[4]  = '{5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "lu_rs2_unused"};
    vecs[5]  = '{5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NONE, "alu_no_lu"};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_BR,   "branch"};
    vecs[7]  = '{5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_BR,   "branch_over_lu"};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_MD,   "muldiv_over_br"};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, O_MEM,  "mem_over_md"};
    vecs[10] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_NONE, "mem_hit"};

    // Reset drive and reset state
    #1 check("rst_outputs", 32'(obs), 32'(O_RST));
    @(negedge clk);
    check("rst_state", 32'(state), 32'(RUN));
    check("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    rst = 1'b0;

    // RUN-state priority table
    for (int i = 0; i < 11; i++) begin
      do_reset();
      id_rs1_addr = vecs[i].rs1;  id_rs2_addr = vecs[i].rs2;
      id_uses_rs2 = vecs[i].uses_rs2; ex_rd_addr = vecs[i].rd;
      ex_mem_read = vecs[i].mem_read; ex_branch_taken = vecs[i].branch;
      ex_is_muldiv = vecs[i].muldiv; mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      #1 check(vecs[i].name, 32'(obs), 32'(vecs[i].exp));
    end

    // Load-use stalls for exactly one cycle, then a bubble sits in EX
    do_reset();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5;
    #1 check("lu_seq_c0", 32'(obs), 32'(O_LU));
    @(negedge clk);
    ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
    #1 check("lu_seq_c1", 32'(obs), 32'(O_NONE));
    check("lu_seq_cnt", 32'(stall_cycles), 32'd1);

    // Memory wait of 3 cycles with a branch held in EX
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    #1 check("memw_c0", 32'(obs), 32'(O_MEM));
    @(negedge clk);
    #1 check("memw_c1", 32'(obs), 32'(O_MEM));
    check("memw_state", 32'(state), 32'(MEM_WAIT));
    @(negedge clk);
    #1 check("memw_c2", 32'(obs), 32'(O_MEM));
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("memw_release", 32'(obs), 32'(O_NONE));
    @(negedge clk);
    mem_req = 1'b0; mem_ready = 1'b0;
    #1 check("memw_redirect", 32'(obs), 32'(O_BR));
    check("memw_state_run", 32'(state), 32'(RUN));
    check("memw_cnt", 32'(stall_cycles), 32'd3);

    // Held mul/div: one start pulse, 4 EX cycles (3 stalled + release), branch ignored while busy
    do_reset();
    ex_is_muldiv = 1'b1;
    #1 check("md_c0", 32'(obs), 32'(O_MD));
    @(negedge clk);
    ex_branch_taken = 1'b1;
    #1 check("md_c1", 32'(obs), 32'(O_MDW));
    check("md_state", 32'(state), 32'(MULDIV_WAIT));
    @(negedge clk);
    #1 check("md_c2", 32'(obs), 32'(O_MDW));
    @(negedge clk);
    #1 check("md_release", 32'(obs), 32'(O_NONE));
    check("md_state_rel", 32'(state), 32'(MULDIV_WAIT));
    @(negedge clk);
    ex_is_muldiv = 1'b0; ex_branch_taken = 1'b0;
    #1 check("md_state_run", 32'(state), 32'(RUN));
    check("md_cnt", 32'(stall_cycles), 32'd3);

    // Timeout after 5 wait cycles, counter saturation, sticky flag, reset clears
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      #1 check($sformatf("timeout_w%0d", k), 32'(mem_timeout), 32'(k >= 6));
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    #1 check("cnt_saturate", 32'(stall_cycles), 32'd15);
    check("timeout_state", 32'(state), 32'(MEM_WAIT));
    mem_ready = 1'b1;
    @(negedge clk);
    mem_req = 1'b0; mem_ready = 1'b0;
    #1 check("timeout_sticky", 32'(mem_timeout), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 check("timeout_cleared", 32'(mem_timeout), 32'd0);
    check("timeout_rst_state", 32'(state), 32'(RUN));
    check("timeout_rst_cnt", 32'(stall_cycles), 32'd0);

    // Reset arriving mid mul/div
    do_reset();
    ex_is_muldiv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("mdrst_outputs", 32'(obs), 32'(O_RST));
    @(negedge clk);
    rst = 1'b0; ex_is_muldiv = 1'b0;
    #1 check("mdrst_state", 32'(state), 32'(RUN));
    check("mdrst_no_stall", 32'(obs), 32'(O_NONE));
    @(negedge clk);
    #1 check("mdrst_still_idle", 32'(obs), 32'(O_NONE));
    check("mdrst_state2", 32'(state), 32'(RUN));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
